// File: rtl/rename_pkg.sv
// Shared rename-stage types: physical register index, free-count width and the
// prefetched-slot record used by the free-list allocator.
package rename_pkg;
   localparam int PREG_W   = 6;
   localparam int NUM_PREG = 2 ** PREG_W;

   typedef logic [PREG_W-1:0] preg_t;
   typedef logic [PREG_W:0]   count_t;

   typedef struct packed {
      logic  valid;
      preg_t preg;
   } preg_slot_t;

   function automatic logic slot_holds(input preg_slot_t s, input preg_t p);
      return s.valid && (s.preg == p);
   endfunction
endpackage

// File: rtl/find_two_set.sv
// Priority encoder: lowest and second-lowest set bit of a vector, with found flags.
module find_two_set #(
   parameter int N = 64,
   parameter int W = 6
) (
   input  logic [N-1:0] i_vec,
   output logic [W-1:0] o_idx0,
   output logic         o_found0,
   output logic [W-1:0] o_idx1,
   output logic         o_found1
);
   always_comb begin
      o_idx0   = '0;
      o_found0 = 1'b0;
      o_idx1   = '0;
      o_found1 = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i_vec[i]) begin
            if (!o_found0) begin
               o_idx0   = W'(i);
               o_found0 = 1'b1;
            end else if (!o_found1) begin
               o_idx1   = W'(i);
               o_found1 = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/preg_free_list_alloc.sv
// Physical-register free list for the INT + LS rename lanes: bitmap of free
// registers, two prefetched slots granted all-or-nothing, ROB commit reclaim.
module preg_free_list_alloc
   import rename_pkg::*;
(
   input  logic              clk,
   input  logic              res,
   input  logic              alloc_int_req,
   input  logic              alloc_ls_req,
   output logic [PREG_W-1:0] alloc_int_preg,
   output logic [PREG_W-1:0] alloc_ls_preg,
   output logic              alloc_stall,
   input  logic              free0_valid,
   input  logic [PREG_W-1:0] free0_preg,
   input  logic              free1_valid,
   input  logic [PREG_W-1:0] free1_preg,
   output logic [PREG_W:0]   free_count,
   output logic              err_double_free
);
   logic [NUM_PREG-1:0] r_free_map;
   preg_slot_t          r_slot0, r_slot1;
   count_t              r_free_count;
   logic                r_err;

   logic [1:0] w_need, w_have, w_used, w_refill;
   logic       w_stall, w_grant_int, w_grant_ls;

   assign w_need      = {1'b0, alloc_int_req} + {1'b0, alloc_ls_req};
   assign w_have      = {1'b0, r_slot0.valid} + {1'b0, r_slot1.valid};
   assign w_stall     = w_need > w_have;
   assign w_grant_int = alloc_int_req & ~w_stall;
   assign w_grant_ls  = alloc_ls_req & ~w_stall;
   assign w_used      = w_stall ? 2'd0 : w_need;
   assign w_refill    = 2'd2 - w_have;

   assign alloc_stall     = w_stall;
   assign alloc_int_preg  = w_grant_int ? r_slot0.preg : '0;
   assign alloc_ls_preg   = !w_grant_ls ? '0 : (alloc_int_req ? r_slot1.preg : r_slot0.preg);
   assign free_count      = r_free_count;
   assign err_double_free = r_err;

   preg_t w_low0, w_low1;
   logic  w_found0, w_found1;

   find_two_set #(.N(NUM_PREG), .W(PREG_W)) u_find (
      .i_vec    (r_free_map),
      .o_idx0   (w_low0),
      .o_found0 (w_found0),
      .o_idx1   (w_low1),
      .o_found1 (w_found1)
   );

   // Slots stay compacted (slot1 valid implies slot0 valid); refills only go
   // into slots that were already empty at the start of the cycle.
   preg_slot_t w_rem0, w_rem1, w_fill_a, w_fill_b, w_next0, w_next1;
   always_comb begin
      w_rem0 = '0;
      w_rem1 = '0;
      case (w_used)
         2'd0: begin
            w_rem0 = r_slot0;
            w_rem1 = r_slot1;
         end
         2'd1:    w_rem0 = r_slot1;
         default: ;
      endcase
      w_fill_a.valid = w_found0 && (w_refill != 2'd0);
      w_fill_a.preg  = w_low0;
      w_fill_b.valid = w_found1 && (w_refill == 2'd2);
      w_fill_b.preg  = w_low1;
      w_next0 = w_rem0.valid ? w_rem0 : w_fill_a;
      w_next1 = w_rem1.valid ? w_rem1 : (w_rem0.valid ? w_fill_a : w_fill_b);
   end

   logic w_f0_live, w_f1_live, w_f0_bad, w_f1_bad, w_dup;
   logic w_f0_ok, w_f1_ok, w_err_now;

   assign w_f0_live = free0_valid && (free0_preg != '0);
   assign w_f1_live = free1_valid && (free1_preg != '0);
   assign w_f0_bad  = r_free_map[free0_preg] || slot_holds(r_slot0, free0_preg)
                      || slot_holds(r_slot1, free0_preg);
   assign w_f1_bad  = r_free_map[free1_preg] || slot_holds(r_slot0, free1_preg)
                      || slot_holds(r_slot1, free1_preg);
   assign w_dup     = w_f0_live && w_f1_live && (free0_preg == free1_preg);
   assign w_f0_ok   = w_f0_live && !w_f0_bad;
   assign w_f1_ok   = w_f1_live && !w_f1_bad && !w_dup;
   assign w_err_now = (w_f0_live && w_f0_bad) || (w_f1_live && w_f1_bad) || w_dup;

   logic [NUM_PREG-1:0] w_load_mask, w_free_mask;
   for (genvar gi = 0; gi < NUM_PREG; gi++) begin : g_mask
      assign w_load_mask[gi] = (w_fill_a.valid && (w_fill_a.preg == PREG_W'(gi)))
                               || (w_fill_b.valid && (w_fill_b.preg == PREG_W'(gi)));
      assign w_free_mask[gi] = (w_f0_ok && (free0_preg == PREG_W'(gi)))
                               || (w_f1_ok && (free1_preg == PREG_W'(gi)));
   end

   always_ff @(posedge clk) begin
      if (res) begin
         r_free_map   <= {{(NUM_PREG-1){1'b1}}, 1'b0};
         r_slot0      <= '0;
         r_slot1      <= '0;
         r_free_count <= count_t'(NUM_PREG - 1);
         r_err        <= 1'b0;
      end else begin
         // Loaded bits were set at cycle start and legal frees were clear, so the masks never overlap.
         r_free_map   <= (r_free_map & ~w_load_mask) | w_free_mask;
         r_slot0      <= w_next0;
         r_slot1      <= w_next1;
         r_free_count <= r_free_count + count_t'(w_f0_ok) + count_t'(w_f1_ok) - count_t'(w_used);
         r_err        <= r_err | w_err_now;
      end
   end
endmodule

// File: tb/tb_preg_free_list_alloc.sv
// Randomised and directed bench for the physical-register free list, checked by
// a scoreboard fed from a pool/queue reference model.
module tb_preg_free_list_alloc;
   localparam int NP = 64;

   logic       clk = 1'b0;
   logic       res, alloc_int_req, alloc_ls_req, alloc_stall;
   logic       free0_valid, free1_valid, err_double_free;
   logic [5:0] alloc_int_preg, alloc_ls_preg, free0_preg, free1_preg;
   logic [6:0] free_count;

   always #5 clk = ~clk;

   preg_free_list_alloc dut (
      .clk             (clk),
      .res             (res),
      .alloc_int_req   (alloc_int_req),
      .alloc_ls_req    (alloc_ls_req),
      .alloc_int_preg  (alloc_int_preg),
      .alloc_ls_preg   (alloc_ls_preg),
      .alloc_stall     (alloc_stall),
      .free0_valid     (free0_valid),
      .free0_preg      (free0_preg),
      .free1_valid     (free1_valid),
      .free1_preg      (free1_preg),
      .free_count      (free_count),
      .err_double_free (err_double_free)
   );

   typedef struct {
      int cyc;
      bit ri;
      bit rl;
      bit stall;
      int ip;
      int lp;
      int cnt;
      bit err;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // Reference model: pool of free registers plus an ordered queue of prefetched ones.
   bit   pool[NP];
   int   slotq[$];
   bit   m_err;
   bit   m_valid = 0;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0d, required %0d", name, cyc, act, req);
      end
   endtask

   function automatic bit in_q(input int q[$], input int v);
      foreach (q[i]) if (q[i] == v) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int pool_count();
      int n = 0;
      for (int i = 0; i < NP; i++) n += int'(pool[i]);
      return n;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NP; i++) pool[i] = (i != 0);
      slotq.delete();
      m_err = 1'b0;
   endfunction

   function automatic exp_t model_eval(input bit ri, input bit rl);
      exp_t e;
      int   have = slotq.size();
      int   need = int'(ri) + int'(rl);
      e.ri = ri; e.rl = rl; e.cyc = cyc;
      e.stall = need > have;
      e.ip = 0; e.lp = 0;
      e.cnt = pool_count() + have;
      e.err = m_err;
      if (!e.stall) begin
         if (ri) e.ip = slotq[0];
         if (rl) e.lp = ri ? slotq[1] : slotq[0];
      end
      return e;
   endfunction

   function automatic void model_update(input bit ri, input bit rl, input bit f0v, input int f0p,
                                        input bit f1v, input int f1p);
      bit snap[NP];
      int held[$];
      int have, need, k;
      snap = pool;
      held = slotq;
      have = slotq.size();
      need = int'(ri) + int'(rl);
      if (need <= have) repeat (need) void'(slotq.pop_front());
      k = 2 - have;
      for (int i = 0; i < NP && k > 0; i++) begin
         if (snap[i]) begin
            slotq.push_back(i);
            pool[i] = 1'b0;
            k--;
         end
      end
      if (f0v && f0p != 0) begin
         if (snap[f0p] || in_q(held, f0p)) m_err = 1'b1;
         else pool[f0p] = 1'b1;
      end
      if (f1v && f1p != 0) begin
         if (snap[f1p] || in_q(held, f1p) || (f0v && f0p == f1p)) m_err = 1'b1;
         else pool[f1p] = 1'b1;
      end
   endfunction

   // A register held by rename (neither free nor prefetched), or -1.
   function automatic int pick_alloc();
      int cand[$];
      for (int i = 1; i < NP; i++) if (!pool[i] && !in_q(slotq, i)) cand.push_back(i);
      if (cand.size() == 0) return -1;
      return cand[$urandom_range(cand.size() - 1)];
   endfunction

   task automatic drive(input bit rs, input bit ri, input bit rl, input bit f0v, input int f0p,
                        input bit f1v, input int f1p);
      exp_t e;
      @(posedge clk);
      #1;
      res = rs; alloc_int_req = ri; alloc_ls_req = rl;
      free0_valid = f0v; free0_preg = 6'(f0p);
      free1_valid = f1v; free1_preg = 6'(f1p);
      cyc++;
      if (m_valid) begin
         e = model_eval(ri, rl);
         sb_q.push_back(e);
         model_update(ri, rl, f0v, f0p, f1v, f1p);
      end
      if (rs) begin
         model_reset();
         m_valid = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: outputs are presented every cycle; compare mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            $display("cycle %0d req int=%0d ls=%0d -> stall=%0d int_preg=%0d ls_preg=%0d count=%0d err=%0d",
                     e.cyc, e.ri, e.rl, alloc_stall, alloc_int_preg, alloc_ls_preg, free_count,
                     err_double_free);
            chk("stall", int'(alloc_stall), int'(e.stall));
            chk("int_preg", int'(alloc_int_preg), e.ip);
            chk("ls_preg", int'(alloc_ls_preg), e.lp);
            chk("free_count", int'(free_count), e.cnt);
            chk("err", int'(err_double_free), int'(e.err));
         end
      end
   end

   initial begin
      res = 1; alloc_int_req = 0; alloc_ls_req = 0;
      free0_valid = 0; free0_preg = 0; free1_valid = 0; free1_preg = 0;

      // Reset and first dual grants
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1 chk("reset_count", int'(free_count), 63);
      chk("reset_stall_idle", int'(alloc_stall), 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      #1 chk("dual1_int", int'(alloc_int_preg), 1);
      chk("dual1_ls", int'(alloc_ls_preg), 2);
      drive(0, 1, 1, 0, 0, 0, 0);
      #1 chk("dual2_stall", int'(alloc_stall), 1);
      chk("dual2_count", int'(free_count), 61);
      drive(0, 1, 1, 0, 0, 0, 0);
      #1 chk("dual3_int", int'(alloc_int_preg), 3);
      chk("dual3_ls", int'(alloc_ls_preg), 4);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1 chk("dual_end_count", int'(free_count), 59);

      // Exhaust the free list with single INT requests
      for (int i = 0; i < 80 && (pool_count() + slotq.size()) > 0; i++) drive(0, 1, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0);
      #1 chk("empty_count", int'(free_count), 0);
      chk("empty_stall", int'(alloc_stall), 1);
      drive(0, 1, 0, 1, 17, 0, 0);
      #1 chk("free17_same_cycle", int'(alloc_stall), 1);
      drive(0, 1, 0, 0, 0, 0, 0);
      #1 chk("free17_next_cycle", int'(alloc_stall), 1);
      drive(0, 1, 0, 0, 0, 0, 0);
      #1 chk("free17_grant", int'(alloc_int_preg), 17);

      // Exactly one free register: dual requests stall, single request is served
      drive(0, 0, 0, 1, 5, 0, 0);
      idle(1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 0, 0, 0, 0);
         #1 chk("one_free_stall", int'(alloc_stall), 1);
      end
      drive(0, 1, 0, 0, 0, 0, 0);
      #1 chk("one_free_int", int'(alloc_int_preg), 5);

      // Illegal frees
      drive(0, 0, 0, 1, 20, 0, 0);
      drive(0, 0, 0, 1, 20, 0, 0);
      #1 chk("legal_free_count", int'(free_count), 1);
      chk("legal_free_err", int'(err_double_free), 0);
      drive(0, 0, 0, 1, 9, 1, 9);
      #1 chk("redundant_free_err", int'(err_double_free), 1);
      drive(0, 0, 0, 1, 0, 1, 0);
      #1 chk("dup_port_count", int'(free_count), 2);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1 chk("zero_free_count", int'(free_count), 2);
      chk("err_sticky", int'(err_double_free), 1);

      // Reset mid-stream with 40 registers allocated and slots valid
      drive(1, 0, 0, 0, 0, 0, 0);
      idle(1);
      for (int i = 0; i < 40; i++) drive(0, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 33, 1, 33);
      drive(1, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      #1 chk("midreset_count", int'(free_count), 63);
      chk("midreset_err", int'(err_double_free), 0);
      chk("midreset_stall", int'(alloc_stall), 1);
      drive(0, 1, 1, 0, 0, 0, 0);
      #1 chk("midreset_int", int'(alloc_int_preg), 1);
      chk("midreset_ls", int'(alloc_ls_preg), 2);

      // Random traffic
      for (int n = 0; n < 500; n++) begin
         bit ri, rl, rs, f0v, f1v;
         int p0, p1;
         ri = $urandom_range(0, 99) < 60;
         rl = $urandom_range(0, 99) < 50;
         rs = $urandom_range(0, 249) == 0;
         p0 = pick_alloc();
         p1 = pick_alloc();
         f0v = (p0 > 0) && ($urandom_range(0, 99) < 40);
         f1v = (p1 > 0) && (p1 != p0) && ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 99) < 3) begin
            f1v = 1'b1;
            p1 = $urandom_range(0, 63);
         end
         if (!f0v) p0 = 0;
         if (!f1v) p1 = 0;
         drive(rs, ri, rl, f0v, p0, f1v, p1);
      end

      idle(1);
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/preg_free_list_alloc.md
Name: preg_free_list_alloc

Overview:
- Physical-register free-list manager for the 2-wide (INT + LS) rename stage.
- Owns the free bitmap of the 64-entry physical RF and keeps two prefetched free registers in a 2-entry slot buffer.
- Grants destination registers to the INT and LS rename lanes in program order, all-or-nothing.
- Reclaims registers released by the ROB at commit.

Parameters:
PREG_W, 6, physical register address width
NUM_PREG, 64, number of physical registers (2**PREG_W); P0 hardwired zero, never allocated

Ports:
clk  in  1  clock
res  in  1  reset; one clock; reset is synchronous and active-high
alloc_int_req  in  1  INT lane needs a destination register this cycle
alloc_ls_req  in  1  LS lane needs a destination register (load, not store)
alloc_int_preg  out  PREG_W  register granted to INT
alloc_ls_preg  out  PREG_W  register granted to LS
alloc_stall  out  1  request group cannot be served this cycle
free0_valid  in  1  ROB releases free0_preg
free0_preg  in  PREG_W  register to return
free1_valid  in  1  ROB releases free1_preg
free1_preg  in  PREG_W  register to return
free_count  out  PREG_W+1  free registers, bitmap plus valid slots
err_double_free  out  1  sticky: illegal free seen

Behaviour:
- State: free bitmap free_map[NUM_PREG]; slot0/slot1, each a preg plus valid bit; free_count counter; err flag.
- Reset (synchronous, any cycle, aborts everything):
  - free_map[1..NUM_PREG-1]=1, free_map[0]=0.
  - Slots invalid; free_count=NUM_PREG-1 (63); err_double_free=0.
  - alloc_int_preg=alloc_ls_preg=0; alloc_stall = (any req) since slots are empty.
- Grant (combinational from slot registers):
  - need = alloc_int_req + alloc_ls_req.
  - have = slot0.valid + slot1.valid.
  - alloc_stall = need > have. Stall grants nothing; no partial grant, so INT/LS order is preserved.
  - Not stalled, INT only: INT gets slot0.
  - Not stalled, LS only: LS gets slot0.
  - Not stalled, both: INT gets slot0, LS gets slot1.
  - Ungranted outputs drive 0.
- Slot update (next edge):
  - Unconsumed slot1 shifts into slot0 when slot0 is consumed.
  - Empty slots refill from the lowest-index set bits of free_map as it was at the start of the cycle. Filling two slots takes the two lowest set bits.
  - A loaded register's free_map bit clears.
  - A consumed register is visible as a new slot value 1 cycle later.
  - Fill order: slot0 takes the lowest index.
- Free (next edge):
  - A valid free of preg p sets free_map[p]. It is allocatable no earlier than the cycle after next; never refill from the same-cycle free.
  - preg 0 frees are ignored silently.
  - Freeing a register already set in free_map or held in a valid slot is ignored and sets err_double_free.
  - Both ports freeing the same p in one cycle: counted once, err set.
- free_count: next = count + accepted frees − granted allocs. Range 0..63; it never wraps, because illegal frees are rejected.
- Exhaustion:
  - free_count=0 means both slots are invalid; any request stalls.
  - With exactly 1 free register, single requests are served and dual requests stall indefinitely until a free arrives.
- Simultaneous grant and free in one cycle are independent; both are applied.

Decomposition:
- Shared package rename_pkg: PREG_W, NUM_PREG, typedef preg_t (logic [PREG_W-1:0]), typedef preg_slot_t (struct: valid, preg_t preg).
- One sub-module find_two_set: NUM_PREG-wide priority encoder returning the lowest and second-lowest set indices with found flags. Instantiated once for slot refill.

Test Plan:
- Reset, no requests, 2 cycles → slot0=1, slot1=2, free_count=63, alloc_stall=0.
- Both reqs every cycle for 3 cycles from reset+2 → grants (INT,LS) = (1,2), then a 1-cycle stall, then (3,4); free_count 63→61→61→59.
- Allocate all 63 (single INT reqs) → alloc_stall=1 with free_count=0. Then free0 p=17 → first grant of 17 two cycles later, never earlier.
- free_count=1, both reqs held → stall every cycle, no grant. Drop LS req → INT granted that cycle.
- Free p already free, and free0=free1=p=9 (p allocated) → err_double_free=1 (sticky), free_count +1 only for the legal case; free p=0 → no change.
- Reset asserted mid-stream with slots valid and 40 allocated → next cycle free_count=63, slots invalid, err_double_free=0; two cycles later slot0=1, slot1=2.
